// File: rtl/mips_pipe_pkg.sv
// Shared fetch/decode pipeline types and constants.
package mips_pipe_pkg;

  localparam int DATA_W = 32;
  localparam logic [DATA_W-1:0] NOP_WORD = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] instruction;
    logic [31:0] next_instruct;
  } if_id_entry_t;

endpackage

// File: rtl/if_id_storage.sv
// Register array for IF/ID entries: synchronous write, combinational read.
module if_id_storage #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 2,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [IDX_W-1:0] rd_idx,
  output logic [WIDTH-1:0] rd_data
);

  // Contents need no reset: occupancy gates every read.
  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[wr_idx] <= wr_data;
  end

  assign rd_data = mem[rd_idx];

endmodule

// File: rtl/if_id_stage_buffer.sv
// Elastic IF->ID buffer: DEPTH-entry FIFO with valid/ready, flush-on-branch
// and a saturating count of discarded entries.
module if_id_stage_buffer #(
  parameter int                DATA_W   = mips_pipe_pkg::DATA_W,
  parameter int                DEPTH    = 2,
  parameter logic [DATA_W-1:0] NOP_WORD = mips_pipe_pkg::NOP_WORD,
  parameter int                CNT_W    = 8
) (
  input  logic                       Clk,
  input  logic                       Reset,
  input  logic [DATA_W-1:0]          InInstruction,
  input  logic [DATA_W-1:0]          InNextInstruct,
  input  logic                       InValid,
  output logic                       InReady,
  input  logic                       Flush,
  output logic [DATA_W-1:0]          OutInstruction,
  output logic [DATA_W-1:0]          OutNextInstruct,
  output logic                       OutValid,
  input  logic                       OutReady,
  output logic [$clog2(DEPTH):0]     Occupancy,
  output logic [CNT_W-1:0]           FlushedCount
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int OCC_W = PTR_W + 1;
  localparam int SUM_W = CNT_W + OCC_W + 1;
  localparam logic [SUM_W-1:0] CNT_MAX = SUM_W'({CNT_W{1'b1}});

  logic [PTR_W-1:0]    wr_ptr;
  logic [PTR_W-1:0]    rd_ptr;
  logic [2*DATA_W-1:0] head;
  logic                push;
  logic                pop;
  logic [SUM_W-1:0]    flush_sum;

  // Ready depends only on registered occupancy, never on OutReady.
  assign InReady  = (Occupancy < OCC_W'(DEPTH));
  assign OutValid = (Occupancy != '0);
  assign push     = InValid & InReady & ~Flush;
  assign pop      = OutValid & OutReady & ~Flush;

  assign OutInstruction  = OutValid ? head[2*DATA_W-1:DATA_W] : NOP_WORD;
  assign OutNextInstruct = OutValid ? head[DATA_W-1:0] : '0;

  // The discarded offer counts too, even though it was never stored.
  assign flush_sum = SUM_W'(FlushedCount) + SUM_W'(Occupancy) + SUM_W'(InValid);

  if_id_storage #(
    .WIDTH (2 * DATA_W),
    .DEPTH (DEPTH),
    .IDX_W (PTR_W)
  ) u_storage (
    .clk     (Clk),
    .we      (push),
    .wr_idx  (wr_ptr),
    .wr_data ({InInstruction, InNextInstruct}),
    .rd_idx  (rd_ptr),
    .rd_data (head)
  );

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      Occupancy    <= '0;
      FlushedCount <= '0;
    end else if (Flush) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      Occupancy    <= '0;
      FlushedCount <= (flush_sum > CNT_MAX) ? {CNT_W{1'b1}} : flush_sum[CNT_W-1:0];
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   Occupancy <= Occupancy + OCC_W'(1);
        2'b01:   Occupancy <= Occupancy - OCC_W'(1);
        default: Occupancy <= Occupancy;
      endcase
    end
  end

endmodule

// File: tb/tb_if_id_stage_buffer.sv
// Scoreboard bench: queue-based reference model checked every cycle on the falling edge.
module tb_if_id_stage_buffer;
  import mips_pipe_pkg::*;

  localparam int DEPTH = 2;
  localparam int CNT_W = 8;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic        Clk = 1'b0;
  logic        Reset = 1'b0;
  logic [31:0] InInstruction = '0;
  logic [31:0] InNextInstruct = '0;
  logic        InValid = 1'b0;
  logic        InReady;
  logic        Flush = 1'b0;
  logic [31:0] OutInstruction;
  logic [31:0] OutNextInstruct;
  logic        OutValid;
  logic        OutReady = 1'b0;
  logic [1:0]  Occupancy;
  logic [7:0]  FlushedCount;

  if_id_stage_buffer #(
    .DATA_W   (32),
    .DEPTH    (DEPTH),
    .NOP_WORD (32'h0000_0000),
    .CNT_W    (CNT_W)
  ) dut (
    .Clk             (Clk),
    .Reset           (Reset),
    .InInstruction   (InInstruction),
    .InNextInstruct  (InNextInstruct),
    .InValid         (InValid),
    .InReady         (InReady),
    .Flush           (Flush),
    .OutInstruction  (OutInstruction),
    .OutNextInstruct (OutNextInstruct),
    .OutValid        (OutValid),
    .OutReady        (OutReady),
    .Occupancy       (Occupancy),
    .FlushedCount    (FlushedCount)
  );

  always #5 Clk = ~Clk;

  int n_cmp = 0;
  int n_bad = 0;
  if_id_entry_t exp_q[$];
  int exp_flushed = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: compare DUT against the model, then advance the model with the
  // inputs that the coming rising edge will see.
  always @(negedge Clk) begin
    if (!Reset) begin
      exp_q.delete();
      exp_flushed = 0;
    end else begin
      check("occupancy", 64'(Occupancy), 64'(exp_q.size()));
      check("in_ready", 64'(InReady), 64'(exp_q.size() < DEPTH));
      check("out_valid", 64'(OutValid), 64'(exp_q.size() != 0));
      check("flushed_count", 64'(FlushedCount), 64'(exp_flushed));
      if (exp_q.size() != 0) begin
        check("head_instr", 64'(OutInstruction), 64'(exp_q[0].instruction));
        check("head_npc", 64'(OutNextInstruct), 64'(exp_q[0].next_instruct));
      end else begin
        check("nop_instr", 64'(OutInstruction), 64'(NOP_WORD));
        check("nop_npc", 64'(OutNextInstruct), 64'h0);
      end
      if (Flush) begin
        exp_flushed = exp_flushed + exp_q.size() + int'(InValid);
        if (exp_flushed > CNT_MAX) exp_flushed = CNT_MAX;
        exp_q.delete();
      end else begin
        automatic bit room = (exp_q.size() < DEPTH);
        if (exp_q.size() != 0 && OutReady) void'(exp_q.pop_front());
        if (InValid && room) exp_q.push_back('{InInstruction, InNextInstruct});
      end
    end
  end

  task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] npc,
                       input logic ordy, input logic fl);
    InValid        = v;
    InInstruction  = ins;
    InNextInstruct = npc;
    OutReady       = ordy;
    Flush          = fl;
    @(posedge Clk);
    #1;
  endtask

  initial begin
    repeat (3) @(posedge Clk);
    #1 Reset = 1'b1;
    repeat (2) drive(0, 32'h0, 32'h0, 0, 0);

    // Single push, consumed the cycle after it appears.
    drive(1, 32'h2008_0005, 32'h0000_0004, 1, 0);
    drive(0, 32'h0, 32'h0, 1, 0);
    drive(0, 32'h0, 32'h0, 1, 0);

    // Fill while decode stalls; third offer held until space frees.
    drive(1, 32'h2009_0003, 32'h0000_0008, 0, 0);
    drive(1, 32'h0109_5020, 32'h0000_000C, 0, 0);
    drive(1, 32'hAC0A_0000, 32'h0000_0010, 0, 0);
    drive(1, 32'hAC0A_0000, 32'h0000_0010, 1, 0);
    drive(1, 32'hAC0A_0000, 32'h0000_0010, 1, 0);
    repeat (3) drive(0, 32'h0, 32'h0, 1, 0);

    // Streaming at occupancy 1.
    drive(1, 32'h0, 32'h0000_0100, 0, 0);
    for (int i = 1; i <= 8; i++) drive(1, 32'(i), 32'h100 + 32'(4 * i), 1, 0);
    repeat (2) drive(0, 32'h0, 32'h0, 1, 0);

    // Flush a full buffer with a live offer; push resumes right after.
    drive(1, 32'h1111_0001, 32'h0000_0200, 0, 0);
    drive(1, 32'h1111_0002, 32'h0000_0204, 0, 0);
    drive(1, 32'hDEAD_BEEF, 32'h0000_0208, 1, 1);
    drive(1, 32'h2222_0001, 32'h0000_0300, 0, 0);
    drive(1, 32'h2222_0002, 32'h0000_0304, 0, 0);
    drive(0, 32'h0, 32'h0, 0, 0);

    // Asynchronous reset mid-stream, checked between clock edges.
    #1 Reset = 1'b0;
    #1;
    check("arst_occupancy", 64'(Occupancy), 64'h0);
    check("arst_out_valid", 64'(OutValid), 64'h0);
    check("arst_in_ready", 64'(InReady), 64'h1);
    check("arst_flushed", 64'(FlushedCount), 64'h0);
    check("arst_instr", 64'(OutInstruction), 64'(NOP_WORD));
    check("arst_npc", 64'(OutNextInstruct), 64'h0);
    @(posedge Clk);
    #1 Reset = 1'b1;
    drive(0, 32'h0, 32'h0, 0, 0);

    // Random traffic with occasional flushes.
    for (int i = 0; i < 500; i++)
      drive(1'($urandom_range(0, 3) != 0), $urandom, $urandom,
            1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 15) == 0));

    // Heavy flushing to drive the counter into saturation.
    for (int i = 0; i < 300; i++)
      drive(1'($urandom_range(0, 4) != 0), $urandom, $urandom,
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    repeat (3) drive(0, 32'h0, 32'h0, 1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
